// File: rtl/apb_adder_master.sv
// APB requester for the adder peripheral: write A, write B, compute-read, return the sum.
// Latency 6 edges from accepted start to done with a zero-wait slave; stalls in ACCESS while PREADY=0, aborts after TIMEOUT.
module apb_adder_master #(
    parameter logic [31:0] ADDR_A   = 32'h0,
    parameter logic [31:0] ADDR_B   = 32'h1,
    parameter logic [31:0] ADDR_RES = 32'h2,
    parameter int          TIMEOUT  = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] result,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PRWADDR,
    output logic [31:0] PRWDATA,
    output logic [1:0]  f,
    input  logic [31:0] PRDATA1,
    input  logic        PREADY
);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE, S_ERR} state_t;
    // Step encoding doubles as the slave function code.
    typedef enum logic [1:0] {STEP_A = 2'b01, STEP_B = 2'b10, STEP_RES = 2'b11} step_t;

    localparam int             CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  WAIT_LAST = CW'(TIMEOUT - 1);

    state_t        state, state_d;
    step_t         step, step_d;
    logic [CW-1:0] wait_cnt, wait_d;
    logic [31:0]   opa_q, opa_d, opb_q, opb_d, result_d;
    logic          psel_d, penable_d, pwrite_d, busy_d, done_d, err_d;
    logic [31:0]   addr_d, wdata_d;
    logic [1:0]    f_d;

    always_comb begin
        state_d  = state;
        step_d   = step;
        wait_d   = wait_cnt;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result;
        case (state)
            S_IDLE: begin
                if (start) begin
                    opa_d   = op_a;
                    opb_d   = op_b;
                    step_d  = STEP_A;
                    wait_d  = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                wait_d  = '0;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (PREADY) begin
                    wait_d = '0;
                    case (step)
                        STEP_A: begin
                            step_d  = STEP_B;
                            state_d = S_SETUP;
                        end
                        STEP_B: begin
                            step_d  = STEP_RES;
                            state_d = S_SETUP;
                        end
                        default: begin
                            result_d = PRDATA1;
                            state_d  = S_DONE;
                        end
                    endcase
                end else if (wait_cnt == WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_cnt + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Bus outputs are decoded from the next state so they leave the block registered.
        psel_d    = (state_d == S_SETUP) || (state_d == S_ACCESS);
        penable_d = (state_d == S_ACCESS);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        err_d     = (state_d == S_ERR);
        pwrite_d  = 1'b0;
        addr_d    = '0;
        wdata_d   = '0;
        f_d       = 2'b00;
        if (psel_d) begin
            f_d = step_d;
            case (step_d)
                STEP_A: begin
                    pwrite_d = 1'b1;
                    addr_d   = ADDR_A;
                    wdata_d  = opa_d;
                end
                STEP_B: begin
                    pwrite_d = 1'b1;
                    addr_d   = ADDR_B;
                    wdata_d  = opb_d;
                end
                default: begin
                    pwrite_d = 1'b0;
                    addr_d   = ADDR_RES;
                    wdata_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state    <= S_IDLE;
            step     <= STEP_A;
            wait_cnt <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result   <= '0;
            PSEL     <= 1'b0;
            PENABLE  <= 1'b0;
            PWRITE   <= 1'b0;
            PRWADDR  <= '0;
            PRWDATA  <= '0;
            f        <= 2'b00;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_d;
            step     <= step_d;
            wait_cnt <= wait_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result   <= result_d;
            PSEL     <= psel_d;
            PENABLE  <= penable_d;
            PWRITE   <= pwrite_d;
            PRWADDR  <= addr_d;
            PRWDATA  <= wdata_d;
            f        <= f_d;
            busy     <= busy_d;
            done     <= done_d;
            err      <= err_d;
        end
    end

endmodule

// File: tb/tb_apb_adder_master.sv
// Bench for apb_adder_master: adder slave stub with programmable wait states, protocol monitor,
// vector table, randomized commands against an arithmetic model, and hand-written corner sequences.
module tb_apb_adder_master;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        start;
    logic [31:0] op_a, op_b;
    logic        busy, done, err;
    logic [31:0] result;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PRWADDR, PRWDATA;
    logic [1:0]  f;
    logic [31:0] PRDATA1;
    logic        PREADY;

    apb_adder_master dut (
        .PCLK(PCLK), .PRESET(PRESET), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .err(err), .result(result),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PRWADDR(PRWADDR),
        .PRWDATA(PRWDATA), .f(f), .PRDATA1(PRDATA1), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic [1:0]  fc;
        logic        w;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          wn;
        logic [31:0] exp_res;
    } vec_t;

    int n_cmp = 0, n_fail = 0;
    int n_done = 0, n_err = 0;
    xfer_t xq[$];
    xfer_t cur;
    int    wn_cur = 0;
    logic [1:0] stuck_f = 2'b00;
    bit    junk = 1'b0;
    int    acc_cnt = 0;
    logic [31:0] sa = 0, sb = 0;
    logic  prev_psel = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave stub and protocol monitor, evaluated on the falling edge.
    always @(negedge PCLK) begin
        if (PRESET) begin
            acc_cnt   = 0;
            PREADY    = 1'b0;
            prev_psel = 1'b0;
        end else begin
            if (done) n_done++;
            if (err)  n_err++;
            if (PENABLE && !PSEL) chk("penable_without_psel", 1'b1, 1'b0);
            if (PSEL && !PENABLE) cur = '{fc: f, w: PWRITE, addr: PRWADDR, data: PRWDATA};
            if (PSEL && PENABLE) begin
                chk("psel_before_penable", prev_psel, 1'b1);
                chk("stable_fields",
                    (cur == xfer_t'{fc: f, w: PWRITE, addr: PRWADDR, data: PRWDATA}), 1'b1);
                PREADY  = (acc_cnt >= wn_cur) && (f != stuck_f);
                PRDATA1 = (f == 2'b11) ? sa + sb : $urandom;
                if (PREADY) begin
                    xq.push_back(cur);
                    if (f == 2'b01 && PWRITE) sa = PRWDATA;
                    if (f == 2'b10 && PWRITE) sb = PRWDATA;
                    acc_cnt = 0;
                end else begin
                    acc_cnt++;
                end
            end else begin
                acc_cnt = 0;
                PREADY  = junk ? 1'($urandom) : 1'b0;
                PRDATA1 = $urandom;
            end
            prev_psel = PSEL;
        end
    end

    task automatic check_seq(input logic [31:0] a, input logic [31:0] b);
        xfer_t ex[3];
        ex[0] = '{fc: 2'b01, w: 1'b1, addr: 32'h0, data: a};
        ex[1] = '{fc: 2'b10, w: 1'b1, addr: 32'h1, data: b};
        ex[2] = '{fc: 2'b11, w: 1'b0, addr: 32'h2, data: 32'h0};
        chk("xfer_count", 32'(xq.size()), 32'd3);
        if (xq.size() == 3) begin
            for (int i = 0; i < 3; i++) chk($sformatf("xfer%0d", i), 32'(xq[i] == ex[i]), 32'd1);
        end
    endtask

    task automatic do_cmd(input logic [31:0] a, input logic [31:0] b, input int wn,
                          output int lat, output bit got_done, output bit got_err);
        xq.delete();
        wn_cur = wn;
        @(negedge PCLK);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge PCLK);
        #1 start = 1'b0;
        chk("busy_on_accept", busy, 1'b1);
        lat = 0; got_done = 0; got_err = 0;
        for (int i = 0; i < 100 && !got_done && !got_err; i++) begin
            @(posedge PCLK);
            #1;
            lat++;
            got_done = done;
            got_err  = err;
        end
        chk("cmd_finished", got_done | got_err, 1'b1);
        @(posedge PCLK);
        #1 chk("idle_after_cmd", {busy, done, err, PSEL, PENABLE, f}, 0);
        @(posedge PCLK);
        #1;
    endtask

    initial begin
        vec_t vecs[5];
        int lat;
        bit gd, ge;
        logic [31:0] r0, a, b;
        int wn, d0, e0;
        bit found;

        vecs[0] = '{a: 32'd3,          b: 32'd4,          wn: 1, exp_res: 32'd7};
        vecs[1] = '{a: 32'hFFFFFFFF,   b: 32'd1,          wn: 0, exp_res: 32'h0};
        vecs[2] = '{a: 32'h7FFFFFFF,   b: 32'd1,          wn: 2, exp_res: 32'h80000000};
        vecs[3] = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   wn: 3, exp_res: 32'hFFFFFFFE};
        vecs[4] = '{a: 32'h12345678,   b: 32'h11111111,   wn: 0, exp_res: 32'h23456789};

        PRESET = 1'b1; start = 1'b0; op_a = 0; op_b = 0;
        repeat (2) @(posedge PCLK);
        #1;
        chk("reset_ctrl", {PSEL, PENABLE, PWRITE, busy, done, err, f}, 0);
        chk("reset_addr", PRWADDR, 0);
        chk("reset_wdata", PRWDATA, 0);
        chk("reset_result", result, 0);
        @(negedge PCLK);
        PRESET = 1'b0;

        // Vector table: latency is 3 transfers of (2 + wait) edges each.
        for (int i = 0; i < 5; i++) begin
            do_cmd(vecs[i].a, vecs[i].b, vecs[i].wn, lat, gd, ge);
            chk($sformatf("vec%0d_done", i), gd, 1'b1);
            chk($sformatf("vec%0d_latency", i), lat, 6 + 3 * vecs[i].wn);
            chk($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
            check_seq(vecs[i].a, vecs[i].b);
        end

        // Randomized commands with junk PREADY outside ACCESS.
        junk = 1'b1;
        for (int i = 0; i < 24; i++) begin
            a  = $urandom;
            b  = $urandom;
            wn = $urandom_range(0, 3);
            do_cmd(a, b, wn, lat, gd, ge);
            chk("rnd_done", gd, 1'b1);
            chk("rnd_latency", lat, 6 + 3 * wn);
            chk("rnd_result", result, a + b);
            check_seq(a, b);
        end
        junk = 1'b0;

        // Slave stalls forever on operand B: 3 edges to reach ACCESS B, then TIMEOUT cycles.
        r0 = result; d0 = n_done; e0 = n_err;
        stuck_f = 2'b10;
        do_cmd(32'd10, 32'd20, 0, lat, gd, ge);
        stuck_f = 2'b00;
        chk("timeout_err", ge, 1'b1);
        chk("timeout_no_done", gd, 1'b0);
        chk("timeout_latency", lat, 19);
        chk("timeout_result_held", result, r0);
        chk("timeout_err_pulses", n_err - e0, 1);
        chk("timeout_done_pulses", n_done - d0, 0);
        chk("timeout_xfers", 32'(xq.size()), 32'd1);

        // Second start while busy and start during the done cycle are both dropped.
        xq.delete(); wn_cur = 1; d0 = n_done;
        @(negedge PCLK);
        op_a = 32'd5; op_b = 32'd6; start = 1'b1;
        @(posedge PCLK);
        #1 start = 1'b0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        op_a = 32'd9; op_b = 32'd9; start = 1'b1;
        @(posedge PCLK);
        #1 start = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge PCLK);
            #1 found = done;
        end
        chk("busy_start_done_seen", found, 1'b1);
        start = 1'b1;
        @(posedge PCLK);
        #1 start = 1'b0;
        chk("busy_start_result", result, 32'd11);
        chk("start_in_done_ignored", busy, 1'b0);
        repeat (6) @(posedge PCLK);
        #1;
        chk("busy_start_one_done", n_done - d0, 1);
        chk("busy_start_idle", busy, 1'b0);
        check_seq(32'd5, 32'd6);

        // Asynchronous reset in the middle of the compute read.
        d0 = n_done; e0 = n_err; wn_cur = 2; xq.delete();
        @(negedge PCLK);
        op_a = 32'd7; op_b = 32'd8; start = 1'b1;
        @(posedge PCLK);
        #1 start = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge PCLK);
            found = PENABLE && (f == 2'b11);
        end
        chk("reset_reach_res_access", found, 1'b1);
        #2 PRESET = 1'b1;
        #1;
        chk("midreset_ctrl", {PSEL, PENABLE, PWRITE, busy, done, err, f}, 0);
        chk("midreset_addr", PRWADDR, 0);
        chk("midreset_wdata", PRWDATA, 0);
        chk("midreset_result", result, 0);
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        chk("midreset_no_done", n_done - d0, 0);
        chk("midreset_no_err", n_err - e0, 0);
        do_cmd(32'd1, 32'd2, 1, lat, gd, ge);
        chk("post_reset_done", gd, 1'b1);
        chk("post_reset_result", result, 32'd3);
        check_seq(32'd1, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
